// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   16x-oversampling 8N1 UART receiver. The serial line is synchronised into
//   the board clock domain and sampled at mid-bit using ticks derived from the
//   rising edges of the baud generator's oversample square wave. The
//   oversample wave is treated as ordinary data and never used as a clock.
//   Received bytes are offered on a valid/ready interface.
//
// Parameters
//   DATA_BITS   data bits per frame (LSB first, no parity, one stop bit)
//   OVERSAMPLE  ticks per bit; must be even and at least 4
//
// Ports
//   i_clk        board clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_os_clk     oversample square wave, synchronous to i_clk
//   i_rx         asynchronous serial line, idle high
//   o_data       received byte, stable while o_valid is high
//   o_valid      byte available, held until accepted
//   i_ready      consumer accepts when o_valid & i_ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while previous one pending
//   o_busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_os_clk,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_ZERO      = OS_W'(0);
  localparam logic [OS_W-1:0] OS_ONE       = OS_W'(1);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_ZERO      = BI_W'(0);
  localparam logic [BI_W-1:0] BI_ONE       = BI_W'(1);
  localparam logic [BI_W-1:0] BI_LAST      = BI_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  // Edge detector and line synchroniser
  logic os_q, os_d;
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;

  // Receive FSM and datapath
  state_e                 state_q, state_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [BI_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;

  // Registered outputs
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  // Combinational helpers
  logic tick_s;
  logic rx_s;
  logic deliver_s;
  logic stop_err_s;
  logic accept_s;

  // One tick per rising edge of the oversample wave.
  assign tick_s   = i_os_clk & ~os_q;
  assign rx_s     = rx_sync_q;
  assign accept_s = valid_q & i_ready;

  // Next-state values for the tick edge detector and the two-flop synchroniser.
  always_comb begin
    os_d      = i_os_clk;
    rx_meta_d = i_rx;
    rx_sync_d = rx_meta_q;
  end

  // Receive state machine: start validation, bit sampling and stop check.
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    deliver_s  = 1'b0;
    stop_err_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick_s && !rx_s) begin
          state_d  = S_START;
          os_cnt_d = OS_ZERO;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_START: begin
        if (tick_s) begin
          if (os_cnt_q == OS_HALF_LAST) begin
            // Mid start bit: still low means a real start, high is a glitch.
            if (!rx_s) begin
              state_d   = S_DATA;
              os_cnt_d  = OS_ZERO;
              bit_idx_d = BI_ZERO;
            end else begin
              state_d   = S_IDLE;
              os_cnt_d  = OS_ZERO;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end

      S_DATA: begin
        if (tick_s) begin
          if (os_cnt_q == OS_LAST) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = OS_ZERO;
            bit_idx_d = bit_idx_q + BI_ONE;
            if (bit_idx_q == BI_LAST) begin
              state_d = S_STOP;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end

      S_STOP: begin
        if (tick_s) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = OS_ZERO;
            if (rx_s) begin
              deliver_s = 1'b1;
              state_d   = S_IDLE;
            end else begin
              stop_err_s = 1'b1;
              state_d    = S_WAIT_HIGH;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end else begin
          os_cnt_d = os_cnt_q;
        end
      end

      S_WAIT_HIGH: begin
        // Checked every cycle; a held-low break line never restarts reception.
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end

      default: begin
        state_d   = S_IDLE;
        os_cnt_d  = OS_ZERO;
        bit_idx_d = BI_ZERO;
      end
    endcase
  end

  // Output handshake: load on delivery, drop on accept, flag overrun and errors.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = stop_err_s;
    busy_d      = (state_d != S_IDLE);

    if (deliver_s) begin
      // A same-cycle accept frees the slot for the new byte.
      if (!valid_q || accept_s) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // All state and registered outputs, with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      os_q        <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      os_cnt_q    <= OS_ZERO;
      bit_idx_q   <= BI_ZERO;
      shift_q     <= {DATA_BITS{1'b0}};
      data_q      <= {DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      os_q        <= os_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Frames are serialised at 64 board clocks
//   per bit (oversample tick every 4 clocks). A monitor records delivered
//   bytes, pulse counts and valid-hold violations; scenarios compare those
//   records against table constants or a queue-based reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_os_clk;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_os_clk    (i_os_clk),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Oversample wave: period of 4 board clocks, rising when ph becomes 2.
  int ph = 0;
  initial begin
    i_os_clk = 1'b0;
    forever begin
      @(negedge i_clk);
      ph = (ph + 1) % 4;
      i_os_clk = (ph >= 2);
    end
  end

  // Monitor: sampled after the bench has driven this cycle's inputs.
  logic [7:0] acc_q[$];
  int         vcyc = 0;
  int         ferr_n = 0;
  int         ovr_n = 0;
  int         hold_err = 0;
  logic       pv = 1'b0;
  logic       pacc = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge i_clk) begin
    #2;
    if (o_valid) vcyc++;
    if (o_valid && i_ready) acc_q.push_back(o_data);
    if (o_frame_err) ferr_n++;
    if (o_overrun) ovr_n++;
    if (pv && !pacc && o_valid && (o_data != pd)) hold_err++;
    pv   = o_valid;
    pacc = o_valid && i_ready;
    pd   = o_data;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  function automatic int last_acc();
    if (acc_q.size() > 0) return int'(acc_q[acc_q.size() - 1]);
    else return -1;
  endfunction

  // Align to two clocks after an oversample rising edge, plus an offset.
  task automatic align(input int offset);
    do step(); while (ph != 0);
    repeat (offset) step();
  endtask

  // Serialise one 8N1 frame (64 clocks per bit). Optional ready pulse at
  // clock rp, optional one-cycle reset at clock rst_at (aborts the frame),
  // optional random ready per clock. Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int rp, input int rst_at,
                            input logic rnd_ready, input int offset);
    align(offset);
    for (int c = 0; c < 640; c++) begin
      if (c < 64) i_rx = 1'b0;
      else if (c < 576) i_rx = d[3'((c / 64) - 1)];
      else i_rx = stop_bit;
      if (rnd_ready) i_ready = ($urandom_range(0, 1) != 0);
      else if (rp >= 0 && c == rp) i_ready = 1'b1;
      else if (rp >= 0 && c == rp + 1) i_ready = 1'b0;
      if (c == rst_at) begin
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_rx  = 1'b1;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_acc;
    int         exp_data;
    int         exp_ferr;
    int         exp_vcyc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_acc, b_f, b_o, b_v;
    int exp_q[$];
    int bad_n;
    logic [7:0] rd;
    logic good;

    tbl[0] = '{8'hA5, 1'b1, 1, 32'hA5, 0, 1};
    tbl[1] = '{8'h3C, 1'b0, 0, -1,     1, 0};
    tbl[2] = '{8'h81, 1'b1, 1, 32'h81, 0, 1};
    tbl[3] = '{8'h00, 1'b1, 1, 32'h00, 0, 1};
    tbl[4] = '{8'hFF, 1'b1, 1, 32'hFF, 0, 1};
    tbl[5] = '{8'h5A, 1'b1, 1, 32'h5A, 0, 1};
    tbl[6] = '{8'hC3, 1'b0, 0, -1,     1, 0};

    // Reset state
    i_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    i_rst = 1'b0;
    repeat (10) step();

    // Table-driven frames, consumer always ready
    i_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b_acc = acc_q.size(); b_f = ferr_n; b_o = ovr_n; b_v = vcyc;
      send_frame(tbl[i].data, tbl[i].stop_bit, -1, -1, 1'b0, 0);
      if (!tbl[i].stop_bit) begin
        repeat (160) step();
        chk($sformatf("busy_line_low[%0d]", i), int'(o_busy), 1);
        chk($sformatf("valid_after_ferr[%0d]", i), int'(o_valid), 0);
        i_rx = 1'b1;
      end
      repeat (8) step();
      chk($sformatf("acc_count[%0d]", i), acc_q.size() - b_acc, tbl[i].exp_acc);
      if (tbl[i].exp_acc > 0) chk($sformatf("data[%0d]", i), last_acc(), tbl[i].exp_data);
      chk($sformatf("ferr[%0d]", i), ferr_n - b_f, tbl[i].exp_ferr);
      chk($sformatf("ovr[%0d]", i), ovr_n - b_o, 0);
      chk($sformatf("valid_cycles[%0d]", i), vcyc - b_v, tbl[i].exp_vcyc);
      chk($sformatf("busy_after[%0d]", i), int'(o_busy), 0);
    end

    // Start glitch: low for 4 ticks only
    b_acc = acc_q.size(); b_f = ferr_n; b_v = vcyc;
    align(0);
    i_rx = 1'b0;
    repeat (16) step();
    chk("glitch_busy_high", int'(o_busy), 1);
    i_rx = 1'b1;
    repeat (60) step();
    chk("glitch_busy_low", int'(o_busy), 0);
    chk("glitch_no_valid", vcyc - b_v, 0);
    chk("glitch_no_ferr", ferr_n - b_f, 0);
    send_frame(8'h3C, 1'b1, -1, -1, 1'b0, 0);
    repeat (8) step();
    chk("post_glitch_count", acc_q.size() - b_acc, 1);
    chk("post_glitch_data", last_acc(), 32'h3C);

    // Overrun: two frames, consumer not ready
    i_ready = 1'b0;
    b_acc = acc_q.size(); b_f = ferr_n; b_o = ovr_n;
    send_frame(8'h11, 1'b1, -1, -1, 1'b0, 0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0, 0);
    repeat (8) step();
    chk("ovr_valid", int'(o_valid), 1);
    chk("ovr_data_held", int'(o_data), 32'h11);
    chk("ovr_pulses", ovr_n - b_o, 1);
    chk("ovr_no_ferr", ferr_n - b_f, 0);
    chk("ovr_none_accepted", acc_q.size() - b_acc, 0);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    repeat (3) step();
    chk("ovr_accept_count", acc_q.size() - b_acc, 1);
    chk("ovr_accept_data", last_acc(), 32'h11);
    chk("ovr_valid_drop", int'(o_valid), 0);

    // Accept on the exact completion cycle of the second byte
    send_frame(8'h11, 1'b1, -1, -1, 1'b0, 0);
    b_acc = acc_q.size(); b_o = ovr_n;
    send_frame(8'h22, 1'b1, 610, -1, 1'b0, 0);
    repeat (8) step();
    chk("acc_cmp_valid", int'(o_valid), 1);
    chk("acc_cmp_data", int'(o_data), 32'h22);
    chk("acc_cmp_no_ovr", ovr_n - b_o, 0);
    chk("acc_cmp_count", acc_q.size() - b_acc, 1);
    chk("acc_cmp_first", last_acc(), 32'h11);
    i_ready = 1'b1;
    repeat (4) step();
    chk("acc_cmp_second", last_acc(), 32'h22);
    chk("acc_cmp_drop", int'(o_valid), 0);

    // Reset during data bit 4, with a byte pending
    i_ready = 1'b0;
    send_frame(8'h77, 1'b1, -1, -1, 1'b0, 0);
    repeat (8) step();
    chk("pre_rst_valid", int'(o_valid), 1);
    b_f = ferr_n; b_o = ovr_n;
    send_frame(8'h5A, 1'b1, -1, 350, 1'b0, 0);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_data", int'(o_data), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_ferr", int'(o_frame_err), 0);
    chk("mid_rst_ovr", int'(o_overrun), 0);
    i_ready = 1'b1;
    repeat (20) step();
    b_acc = acc_q.size();
    send_frame(8'h5A, 1'b1, -1, -1, 1'b0, 0);
    repeat (8) step();
    chk("post_rst_count", acc_q.size() - b_acc, 1);
    chk("post_rst_data", last_acc(), 32'h5A);
    chk("post_rst_no_err", (ferr_n - b_f) + (ovr_n - b_o), 0);

    // Randomised frames against a queue reference model
    b_acc = acc_q.size(); b_f = ferr_n; b_o = ovr_n;
    bad_n = 0;
    for (int n = 0; n < 30; n++) begin
      rd   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(rd, good, -1, -1, 1'b1, $urandom_range(0, 3));
      if (good) begin
        exp_q.push_back(int'(rd));
      end else begin
        bad_n++;
        repeat ($urandom_range(0, 80)) step();
        i_rx = 1'b1;
        repeat (8) step();
      end
      repeat ($urandom_range(0, 40)) step();
    end
    i_ready = 1'b1;
    repeat (10) step();
    chk("rnd_count", acc_q.size() - b_acc, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < acc_q.size() - b_acc; k++)
      chk($sformatf("rnd_data[%0d]", k), int'(acc_q[b_acc + k]), exp_q[k]);
    chk("rnd_ferr", ferr_n - b_f, bad_n);
    chk("rnd_ovr", ovr_n - b_o, 0);

    chk("valid_hold_stable", hold_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
